logic_unit: RTL and testbench

Parametrised, pipelined bitwise logic unit for the execute stage of the 3-stage processor. It computes one of eight bitwise functions of two WIDTH-bit operands. It has two pipeline register stages under valid/ready flow control. It replaces the fixed 8-bit combinational AND cell with a width-generic, multi-function, back-pressurable unit and optional result flags.

---
 rtl/logic_unit_pkg.sv | 15 +
 rtl/logic_unit_if.sv | 35 +++
 rtl/logic_unit_stage.sv | 31 +++
 rtl/logic_unit.sv | 83 ++++++++
 tb/tb_logic_unit.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_pkg.sv
// Shared constants for the pipelined bitwise logic unit: op encoding and op width.
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_ANDN = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/logic_unit_if.sv
// Operand/result valid-ready bundle for logic_unit.
// zero/parity exist only when LOGIC_UNIT_FLAGS_EN is defined.
interface logic_unit_if #(parameter int WIDTH = 8);
    import logic_unit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
`ifdef LOGIC_UNIT_FLAGS_EN
    logic             zero;
    logic             parity;
`endif

    modport master (
        output in_valid, op, a, b, out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
        input  zero, parity,
`endif
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
        output zero, parity,
`endif
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/logic_unit_stage.sv
// One valid/ready register stage with a generic payload and a configurable reset value.
module logic_unit_stage #(
    parameter int           W         = 8,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // Load whenever the stage is empty or draining; a missing upstream beat leaves a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= RESET_VAL;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/logic_unit.sv
// Two-stage pipelined bitwise logic unit (8 functions, WIDTH bits) with valid/ready flow control.
// Define LOGIC_UNIT_FLAGS_EN to add registered zero/parity result flags.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    logic_unit_if.slave  bus
);

    localparam int S1_W = OP_W + 2 * WIDTH;

    logic             s1_valid;
    logic             s2_ready;
    logic [S1_W-1:0]  s1_data;
    logic [OP_W-1:0]  s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] fn_result;

    logic_unit_stage #(.W(S1_W), .RESET_VAL('0)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   ({bus.op, bus.a, bus.b}),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    assign s1_op = s1_data[S1_W-1 -: OP_W];
    assign s1_a  = s1_data[2*WIDTH-1 -: WIDTH];
    assign s1_b  = s1_data[WIDTH-1:0];

    always_comb begin
        fn_result = s1_a;
        case (s1_op)
            OP_AND:  fn_result = s1_a & s1_b;
            OP_OR:   fn_result = s1_a | s1_b;
            OP_XOR:  fn_result = s1_a ^ s1_b;
            OP_NAND: fn_result = ~(s1_a & s1_b);
            OP_NOR:  fn_result = ~(s1_a | s1_b);
            OP_XNOR: fn_result = ~(s1_a ^ s1_b);
            OP_ANDN: fn_result = s1_a & ~s1_b;
            OP_PASS: fn_result = s1_a;
            default: fn_result = s1_a;
        endcase
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    // Flags ride in the S2 payload so they share the result's valid bit and stall behaviour.
    localparam int               S2_W   = WIDTH + 2;
    localparam logic [S2_W-1:0]  S2_RST = {{WIDTH{1'b0}}, 1'b1, 1'b0};
    logic [S2_W-1:0] s2_in;
    logic [S2_W-1:0] s2_out;

    assign s2_in = {fn_result, ~|fn_result, ^fn_result};
    assign {bus.result, bus.zero, bus.parity} = s2_out;
`else
    localparam int               S2_W   = WIDTH;
    localparam logic [S2_W-1:0]  S2_RST = '0;
    logic [S2_W-1:0] s2_in;
    logic [S2_W-1:0] s2_out;

    assign s2_in      = fn_result;
    assign bus.result = s2_out;
`endif

    logic_unit_stage #(.W(S2_W), .RESET_VAL(S2_RST)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (s2_out)
    );

endmodule

// File: tb/tb_logic_unit.sv
// Scoreboard bench for logic_unit: truth-table reference model, random and directed traffic.
// Flag checks are compiled in with LOGIC_UNIT_FLAGS_EN.
module tb_logic_unit;

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       p;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   out_cnt = 0;
    int   last_hs_cyc = 0;
    int   last_acc_cyc = 0;
    bit   rand_rdy = 1'b0;
    exp_t sb[$];

    // Output bit i of each function, indexed by {a[i], b[i]}.
    logic [3:0] truth [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                              4'b0001, 4'b1001, 4'b0100, 4'b1100};

    logic_unit_if #(.WIDTH(8))  bus ();
    logic_unit_if #(.WIDTH(32)) bus32 ();

    logic_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic_unit #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t       e;
        logic [3:0] tt;
        int         ones;
        ones = 0;
        tt   = truth[o];
        for (int i = 0; i < 8; i++) begin
            e.res[i] = tt[{x[i], y[i]}];
            ones += int'(e.res[i]);
        end
        e.z = (ones == 0);
        e.p = (ones % 2) == 1;
        return e;
    endfunction

    function automatic exp_t mkExp(input logic [7:0] r);
        exp_t e;
        e.res = r;
        e.z   = (r == 8'h00);
        e.p   = ^r;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Offer one beat until accepted, queueing its expected response at the accept.
    task automatic sendBeat(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input exp_t e);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
            bus.op       = o;
            bus.a        = x;
            bus.b        = y;
            #1;
            if (bus.in_ready) begin
                done = 1'b1;
                sb.push_back(e);
                last_acc_cyc = cyc + 1;
            end
            n++;
            if (!done && n > 200) begin
                reportFail("accept");
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        sendBeat(o, x, y, model(o, x, y));
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_result", 64'(bus.result), 64'd0);
`ifdef LOGIC_UNIT_FLAGS_EN
        checkOutput("rst_zero", 64'(bus.zero), 64'd1);
        checkOutput("rst_parity", 64'(bus.parity), 64'd0);
`endif
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while ((sb.size() != 0 || bus.out_valid) && n < 100);
        if (sb.size() != 0) reportFail(name);
        @(negedge clk);
    endtask

    // Monitor: compare the presented beat with the queue head; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_beat", 64'(bus.result), 64'hDEAD);
                end else begin
                    checkOutput("result", 64'(bus.result), 64'(sb[0].res));
`ifdef LOGIC_UNIT_FLAGS_EN
                    checkOutput("zero", 64'(bus.zero), 64'(sb[0].z));
                    checkOutput("parity", 64'(bus.parity), 64'(sb[0].p));
`endif
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        out_cnt++;
                        last_hs_cyc = cyc + 1;
                    end
                end
            end
        end
    end

    initial begin
        int first_acc;
        int cnt0;
        int n;
        logic [7:0] av;
        logic [7:0] bv;
        logic [7:0] res_tbl [8];
        res_tbl = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA0, 8'hA5};

        bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.op = '0; bus32.a = '0; bus32.b = '0; bus32.out_ready = 1'b1;
        #1;
        checkOutput("init_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("init_result", 64'(bus.result), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=32 NOR of zeros must invert every bit.
        @(negedge clk);
        bus32.in_valid = 1'b1; bus32.op = 3'd4; bus32.a = '0; bus32.b = '0;
        #1;
        checkOutput("w32_in_ready", 64'(bus32.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        n = 0;
        while (!bus32.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (bus32.out_valid) checkOutput("w32_nor", 64'(bus32.result), 64'hFFFF_FFFF);
        else reportFail("w32_nor");

        // All ops on fixed operands.
        for (int i = 0; i < 8; i++) sendBeat(3'(i), 8'hA5, 8'h0F, mkExp(res_tbl[i]));
        drain("ops_drain");

        // Flag corner values.
        sendBeat(3'd0, 8'hF0, 8'h0F, mkExp(8'h00));
        sendBeat(3'd2, 8'h01, 8'h00, mkExp(8'h01));
        drain("flags_drain");

        // Back-pressure: two beats fill the pipe, the third is refused.
        bus.out_ready = 1'b0;
        cnt0 = out_cnt;
        applyStimulus(3'd1, 8'h11, 8'h22);
        applyStimulus(3'd2, 8'h33, 8'h0F);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 3'd6; bus.a = 8'hFF; bus.b = 8'h3C;
        #1;
        checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        applyStimulus(3'd6, 8'hFF, 8'h3C);
        drain("bp_drain");
        checkOutput("bp_count", 64'(out_cnt - cnt0), 64'd3);

        // Streaming: 16 back-to-back beats with no bubbles after fill.
        cnt0 = out_cnt;
        applyStimulus(3'd7, 8'd0, 8'h5A);
        first_acc = last_acc_cyc;
        for (int i = 1; i < 16; i++) applyStimulus(3'd7, 8'(i), 8'h5A);
        drain("stream_drain");
        checkOutput("stream_count", 64'(out_cnt - cnt0), 64'd16);
        checkOutput("stream_span", 64'(last_hs_cyc - first_acc), 64'd17);

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        applyStimulus(3'd3, 8'h12, 8'h34);
        applyStimulus(3'd4, 8'h56, 8'h78);
        applyReset();
        bus.out_ready = 1'b1;
        @(negedge clk);
        #3;
        checkOutput("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

        // Random ops, operands, idle gaps and back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            applyStimulus(3'($urandom_range(0, 7)), av, bv);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
